fetch_seq: RTL and testbench

//  PC sequencer and instruction-fetch controller for the E5-ERV24 RV32I pipeline.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/btfn_predecode.sv | 19 +
 rtl/fetch_seq.sv | 144 ++++++++++++++
 tb/tb_fetch_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg -- shared types, opcodes and B-immediate decode for fetch_seq. Rev 1.0
// ============================================================================
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } state_e;

   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

   function automatic logic [31:0] b_imm(input logic [31:0] instr);
      return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   endfunction

endpackage
`default_nettype wire

// File: rtl/btfn_predecode.sv
`default_nettype none
// ============================================================================
// btfn_predecode -- backward-taken/forward-not-taken guess for a fetched word. Rev 1.0
// ============================================================================
module btfn_predecode
   import fetch_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   output logic        taken,
   output logic [31:0] target
);

   assign taken  = (instr[6:0] == OPC_BRANCH) && instr[31];
   // Fetch addresses are word granular, so the halfword bit of the offset is dropped.
   assign target = (pc + b_imm(instr)) & ~32'd3;

endmodule
`default_nettype wire

// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
// fetch_seq -- fetch PC sequencer and imem request/ack controller. Rev 1.0
// Define FETCH_SEQ_BTFN_EN to enable static BTFN branch prediction.
// ============================================================================
module fetch_seq
   import fetch_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic            ena,
   input  logic            redir_valid,
   input  logic [XLEN-1:0] redir_pc,
   input  logic            stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr,
   output logic            if_pred_taken
);

   state_e          state, next_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_nxt, w_addr_nxt, w_ifpc_nxt, w_instr_nxt;
   logic [XLEN-1:0] w_redir_pc, w_next_pc;
   logic            w_req_nxt, w_valid_nxt, w_pred_nxt;
   logic            w_taken, w_hold_if, w_waiting;

   assign w_redir_pc = {redir_pc[XLEN-1:2], 2'b00};
   assign w_hold_if  = stall && if_valid;
   assign w_waiting  = ((state == FETCH) || (state == DRAIN)) && !imem_ack;

`ifdef FETCH_SEQ_BTFN_EN
   logic [XLEN-1:0] w_target;

   btfn_predecode u_predecode (
      .instr  (imem_rdata),
      .pc     (imem_addr),
      .taken  (w_taken),
      .target (w_target)
   );

   assign w_next_pc = w_taken ? w_target : r_pc + 32'd4;
`else
   assign w_taken   = 1'b0;
   assign w_next_pc = r_pc + 32'd4;
`endif

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state         <= IDLE;
         r_pc          <= RESET_VECTOR;
         imem_req      <= 1'b0;
         imem_addr     <= RESET_VECTOR;
         if_valid      <= 1'b0;
         if_pc         <= '0;
         if_instr      <= NOP_INSTR;
         if_pred_taken <= 1'b0;
      end else if (ena) begin
         state         <= next_state;
         r_pc          <= w_pc_nxt;
         imem_req      <= w_req_nxt;
         imem_addr     <= w_addr_nxt;
         if_valid      <= w_valid_nxt;
         if_pc         <= w_ifpc_nxt;
         if_instr      <= w_instr_nxt;
         if_pred_taken <= w_pred_nxt;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  next_state = FETCH;
         FETCH: begin
            if (redir_valid)
               next_state = imem_ack ? FETCH : DRAIN;
            else if (imem_ack && stall)
               next_state = HOLD;
         end
         HOLD:  if (redir_valid || !stall) next_state = FETCH;
         DRAIN: if (imem_ack) next_state = FETCH;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      w_pc_nxt    = r_pc;
      w_req_nxt   = imem_req;
      w_addr_nxt  = imem_addr;
      w_valid_nxt = w_hold_if ? if_valid : 1'b0;
      w_ifpc_nxt  = if_pc;
      w_instr_nxt = if_instr;
      w_pred_nxt  = if_pred_taken;
      if (redir_valid) begin
         w_pc_nxt    = w_redir_pc;
         w_valid_nxt = 1'b0;
         // An unanswered request cannot be withdrawn; DRAIN swallows its answer.
         if (!w_waiting) begin
            w_req_nxt  = 1'b1;
            w_addr_nxt = w_redir_pc;
         end
      end else begin
         case (state)
            IDLE: begin
               w_req_nxt  = 1'b1;
               w_addr_nxt = r_pc;
            end
            FETCH: begin
               if (imem_ack && w_hold_if) begin
                  // Decode still holds the previous word: drop this one, refetch after stall.
                  w_req_nxt = 1'b0;
               end else if (imem_ack) begin
                  w_valid_nxt = 1'b1;
                  w_ifpc_nxt  = imem_addr;
                  w_instr_nxt = imem_rdata;
                  w_pred_nxt  = w_taken;
                  w_pc_nxt    = w_next_pc;
                  w_req_nxt   = !stall;
                  if (!stall) w_addr_nxt = w_next_pc;
               end
            end
            HOLD: begin
               if (!stall) begin
                  w_req_nxt  = 1'b1;
                  w_addr_nxt = r_pc;
               end
            end
            DRAIN: begin
               if (imem_ack) w_addr_nxt = r_pc;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// tb_fetch_seq -- vector table, directed corner sequences and a randomized
// stream check of the delivered instruction order for fetch_seq.
module tb_fetch_seq;

   logic        clk = 1'b0;
   logic        nreset, ena, redir_valid, stall, imem_ack;
   logic [31:0] redir_pc, imem_rdata;
   logic        imem_req, if_valid, if_pred_taken;
   logic [31:0] imem_addr, if_pc, if_instr;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic        br_en = 1'b0;

   fetch_seq dut (
      .clk           (clk),
      .nreset        (nreset),
      .ena           (ena),
      .redir_valid   (redir_valid),
      .redir_pc      (redir_pc),
      .stall         (stall),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .if_instr      (if_instr),
      .if_pred_taken (if_pred_taken)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ena;
      logic        ack;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } vec_t;

   vec_t tbl [12];

   // Instruction memory image: addi-style words tagged with their address.
   function automatic logic [31:0] mem(input logic [31:0] a);
      if (br_en && a == 32'h20) return 32'hFE00_0CE3;  // beq x0,x0,-8
      if (br_en && a == 32'h40) return 32'h0000_0463;  // beq x0,x0,+8
      return {a[26:2], 7'h13};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_if(input string tag, input logic req, input logic [31:0] addr,
                         input logic v, input logic [31:0] pc, input logic [31:0] instr);
      chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
      if (req) chk({tag, ".addr"}, imem_addr, addr);
      chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
      if (v) begin
         chk({tag, ".if_pc"}, if_pc, pc);
         chk({tag, ".if_instr"}, if_instr, instr);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic a, input logic s, input logic r,
                        input logic [31:0] rp);
      ena         = e;
      imem_ack    = a;
      stall       = s;
      redir_valid = r;
      redir_pc    = rp;
      imem_rdata  = mem(imem_addr);
   endtask

   task automatic set_row(input int i, input logic e, input logic a, input logic req,
                          input logic [31:0] addr, input logic v, input logic [31:0] pc);
      tbl[i].ena   = e;
      tbl[i].ack   = a;
      tbl[i].req   = req;
      tbl[i].addr  = addr;
      tbl[i].valid = v;
      tbl[i].pc    = pc;
      tbl[i].instr = (pc == 32'hFFFF_FFFF) ? 32'h0000_0013 : mem(pc);
   endtask

   initial begin
      logic [31:0] exp_pc, last_addr, exp_addr;
      logic        last_pend, last_redir, exp_pred;
      int          ndeliv;

      set_row(0,  1, 0, 0, 32'h00, 0, 32'h00);
      set_row(1,  1, 1, 1, 32'h00, 0, 32'h00);
      set_row(2,  1, 1, 1, 32'h04, 1, 32'h00);
      set_row(3,  1, 1, 1, 32'h08, 1, 32'h04);
      set_row(4,  1, 0, 1, 32'h0C, 1, 32'h08);
      set_row(5,  1, 0, 1, 32'h0C, 0, 32'h08);
      set_row(6,  1, 0, 1, 32'h0C, 0, 32'h08);
      set_row(7,  1, 1, 1, 32'h0C, 0, 32'h08);
      set_row(8,  0, 0, 1, 32'h10, 1, 32'h0C);
      set_row(9,  1, 0, 1, 32'h10, 1, 32'h0C);
      set_row(10, 1, 1, 1, 32'h10, 0, 32'h0C);
      set_row(11, 1, 0, 1, 32'h14, 1, 32'h10);

      nreset = 1'b0;
      drive(0, 0, 0, 0, 32'h0);
      tick;
      tick;
      chk("rst.req", {31'd0, imem_req}, 32'd0);
      chk("rst.addr", imem_addr, 32'h0);
      chk("rst.valid", {31'd0, if_valid}, 32'd0);
      chk("rst.if_pc", if_pc, 32'h0);
      chk("rst.if_instr", if_instr, 32'h0000_0013);
      chk("rst.pred", {31'd0, if_pred_taken}, 32'd0);
      nreset = 1'b1;

      // Back-to-back acks, a 3-cycle delayed ack, and an ena=0 freeze.
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].ena, tbl[i].ack, 1'b0, 1'b0, 32'h0);
         chk_if($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].valid,
                tbl[i].pc, tbl[i].instr);
         tick;
      end

      // Redirect while the 0x14 request is outstanding: drain, then fetch 0x100.
      drive(1, 0, 0, 1, 32'h103); tick;
      chk_if("drain1", 1, 32'h14, 0, 0, 0);   drive(1, 1, 0, 0, 0); tick;
      chk_if("drain2", 1, 32'h100, 0, 0, 0);  drive(1, 1, 0, 0, 0); tick;
      chk_if("redir_data", 1, 32'h104, 1, 32'h100, mem(32'h100));
      // Stall for 4 cycles with a valid word presented.
      drive(1, 1, 1, 0, 0); tick;
      for (int k = 0; k < 3; k++) begin
         chk_if($sformatf("stall%0d", k), 0, 0, 1, 32'h100, mem(32'h100));
         drive(1, 0, 1, 0, 0); tick;
      end
      chk_if("stall_last", 0, 0, 1, 32'h100, mem(32'h100)); drive(1, 0, 0, 0, 0); tick;
      chk_if("resume", 1, 32'h104, 0, 0, 0);  drive(1, 1, 0, 0, 0); tick;
      chk_if("resume_data", 1, 32'h108, 1, 32'h104, mem(32'h104));
      // Redirect together with stall.
      drive(1, 1, 1, 1, 32'h200); tick;
      chk_if("redir_stall", 1, 32'h200, 0, 0, 0); drive(1, 1, 0, 0, 0); tick;
      chk_if("redir_stall_data", 1, 32'h204, 1, 32'h200, mem(32'h200));
      // Backward and forward branches.
      br_en = 1'b1;
      drive(1, 1, 0, 1, 32'h20); tick;
      chk_if("br_back_req", 1, 32'h20, 0, 0, 0); drive(1, 1, 0, 0, 0); tick;
`ifdef FETCH_SEQ_BTFN_EN
      exp_addr = 32'h18;
      exp_pred = 1'b1;
`else
      exp_addr = 32'h24;
      exp_pred = 1'b0;
`endif
      chk_if("br_back", 1, exp_addr, 1, 32'h20, 32'hFE00_0CE3);
      chk("br_back.pred", {31'd0, if_pred_taken}, {31'd0, exp_pred});
      drive(1, 1, 0, 1, 32'h40); tick;
      chk_if("br_fwd_req", 1, 32'h40, 0, 0, 0); drive(1, 1, 0, 0, 0); tick;
      chk_if("br_fwd", 1, 32'h44, 1, 32'h40, 32'h0000_0463);
      chk("br_fwd.pred", {31'd0, if_pred_taken}, 32'd0);

      // Asynchronous reset with a request in flight.
      imem_ack = 1'b0;
      #3 nreset = 1'b0;
      #1;
      chk("arst.req", {31'd0, imem_req}, 32'd0);
      chk("arst.addr", imem_addr, 32'h0);
      chk("arst.valid", {31'd0, if_valid}, 32'd0);
      chk("arst.if_pc", if_pc, 32'h0);
      chk("arst.if_instr", if_instr, 32'h0000_0013);
      br_en = 1'b0;
      tick;
      nreset = 1'b1;

      // Random traffic: delivered words must follow program order from the
      // last redirect, and the handshake must stay stable until acked.
      exp_pc     = 32'h0;
      last_pend  = 1'b0;
      last_redir = 1'b0;
      last_addr  = 32'h0;
      ndeliv     = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic        e, s, r, a;
         logic [31:0] rp;
         if (last_pend) begin
            chk("hs.req", {31'd0, imem_req}, 32'd1);
            chk("hs.addr", imem_addr, last_addr);
         end
         if (last_redir) chk("flush.valid", {31'd0, if_valid}, 32'd0);
         e  = ($urandom_range(9) != 0);
         s  = ($urandom_range(3) == 0);
         r  = e && ($urandom_range(19) == 0);
         a  = e && imem_req && ($urandom_range(1) == 1);
         rp = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15))
                                       : $urandom_range(32'hFFF);
         drive(e, a, s, r, rp);
         if (e && if_valid && !s) begin
            chk("stream.pc", if_pc, exp_pc);
            chk("stream.instr", if_instr, mem(exp_pc));
            chk("stream.pred", {31'd0, if_pred_taken}, 32'd0);
            exp_pc = exp_pc + 32'd4;
            ndeliv++;
         end
         if (r) exp_pc = rp & ~32'd3;
         last_pend  = imem_req && !a;
         last_addr  = imem_addr;
         last_redir = r;
         tick;
      end
      chk("stream.progress", {31'd0, ndeliv > 200}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
